// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Resolves RISC-V conditional branches in the EX stage. The unit decodes
// funct3 directly, compares the two operands, computes the branch target
// PC+Imm, and flags a mispredict against the fetch-stage prediction. The
// result comes out PIPE_STAGES cycles after the op is presented (1 or 2).
//
// Parameters:
//   DATA_WIDTH  - operand width (DataA/DataB)
//   ADDR_WIDTH  - PC / Imm / Target width
//   PIPE_STAGES - latency in cycles, 1 or 2
//   CNT_WIDTH   - width of each performance counter
//
// Ports:
//   CLK, RST_n        - clock (rising edge), async active-low reset
//   InValid, Flush    - op present this cycle / kill everything in flight
//   Funct3            - branch type (000,001,100,101,110,111 legal)
//   DataA, DataB      - rs1 / rs2 operands
//   PC, Imm           - branch address and sign-extended B-immediate
//   PredTaken         - fetch-stage prediction carried with the op
//   ClrCnt            - synchronous clear of both performance counters
//   OutValid, Taken, Target, Mispredict, BrEq, BrLT, IllegalOp - result
//   BrCount, MispCount - saturating counters of legal / mispredicted branches
//
// Handshake: there is no backpressure. An op is accepted on every rising
// edge where InValid=1 and Flush=0; its result is presented for exactly one
// cycle with OutValid=1, PIPE_STAGES cycles later.
//
// Optional feature macro: BRU_PERF_CNT_EN enables the performance counters.
// Without it BrCount/MispCount read 0 and ClrCnt is ignored.
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int PIPE_STAGES = 1,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                  CLK,
   input  logic                  RST_n,
   input  logic                  InValid,
   input  logic                  Flush,
   input  logic [2:0]            Funct3,
   input  logic [DATA_WIDTH-1:0] DataA,
   input  logic [DATA_WIDTH-1:0] DataB,
   input  logic [ADDR_WIDTH-1:0] PC,
   input  logic [ADDR_WIDTH-1:0] Imm,
   input  logic                  PredTaken,
   input  logic                  ClrCnt,
   output logic                  OutValid,
   output logic                  Taken,
   output logic [ADDR_WIDTH-1:0] Target,
   output logic                  Mispredict,
   output logic                  BrEq,
   output logic                  BrLT,
   output logic                  IllegalOp,
   output logic [CNT_WIDTH-1:0]  BrCount,
   output logic [CNT_WIDTH-1:0]  MispCount
);

   // Operands feeding the compare/add: raw inputs (1 stage) or stage-1 regs.
   logic                  stgValid;
   logic [2:0]            stgFunct3;
   logic [DATA_WIDTH-1:0] stgDataA;
   logic [DATA_WIDTH-1:0] stgDataB;
   logic [ADDR_WIDTH-1:0] stgPC;
   logic [ADDR_WIDTH-1:0] stgImm;
   logic                  stgPred;

   generate
      if (PIPE_STAGES == 1) begin : gDirect
         assign stgValid  = InValid;
         assign stgFunct3 = Funct3;
         assign stgDataA  = DataA;
         assign stgDataB  = DataB;
         assign stgPC     = PC;
         assign stgImm    = Imm;
         assign stgPred   = PredTaken;
      end else if (PIPE_STAGES == 2) begin : gStaged
         logic                  s1Valid;
         logic [2:0]            s1Funct3;
         logic [DATA_WIDTH-1:0] s1DataA;
         logic [DATA_WIDTH-1:0] s1DataB;
         logic [ADDR_WIDTH-1:0] s1PC;
         logic [ADDR_WIDTH-1:0] s1Imm;
         logic                  s1Pred;

         always_ff @(posedge CLK or negedge RST_n) begin
            if (!RST_n) begin
               s1Valid  <= 1'b0;
               s1Funct3 <= '0;
               s1DataA  <= '0;
               s1DataB  <= '0;
               s1PC     <= '0;
               s1Imm    <= '0;
               s1Pred   <= 1'b0;
            end else begin
               s1Valid <= InValid & ~Flush;
               // Payload only moves with a live op, which keeps idle toggling low.
               if (InValid && !Flush) begin
                  s1Funct3 <= Funct3;
                  s1DataA  <= DataA;
                  s1DataB  <= DataB;
                  s1PC     <= PC;
                  s1Imm    <= Imm;
                  s1Pred   <= PredTaken;
               end
            end
         end

         assign stgValid  = s1Valid;
         assign stgFunct3 = s1Funct3;
         assign stgDataA  = s1DataA;
         assign stgDataB  = s1DataB;
         assign stgPC     = s1PC;
         assign stgImm    = s1Imm;
         assign stgPred   = s1Pred;
      end else begin : gBadPipeStages
         $error("branch_resolve_unit: PIPE_STAGES must be 1 or 2");
      end
   endgenerate

   // Compare and target computation.
   logic                  cmpEq;
   logic                  cmpLt;
   logic                  isSigned;
   logic                  isIllegal;
   logic                  resTaken;
   logic [ADDR_WIDTH-1:0] resTarget;

   always_comb begin
      isSigned  = (stgFunct3[2:1] == 2'b10);
      isIllegal = (stgFunct3[2:1] == 2'b01);
      cmpEq     = (stgDataA == stgDataB);
      // BEQ/BNE also get the unsigned compare so BrLT is always defined.
      cmpLt     = isSigned ? ($signed(stgDataA) < $signed(stgDataB))
                           : (stgDataA < stgDataB);
      // funct3[2] selects LT vs EQ, funct3[0] inverts the condition.
      resTaken  = ~isIllegal & ((stgFunct3[2] ? cmpLt : cmpEq) ^ stgFunct3[0]);
      resTarget = stgPC + stgImm;
   end

   // Result register.
   logic                  outValidQ;
   logic                  takenQ;
   logic                  illegalQ;
   logic                  predQ;
   logic [ADDR_WIDTH-1:0] targetQ;
   logic                  brEqQ;
   logic                  brLtQ;

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         outValidQ <= 1'b0;
         takenQ    <= 1'b0;
         illegalQ  <= 1'b0;
         predQ     <= 1'b0;
         targetQ   <= '0;
         brEqQ     <= 1'b0;
         brLtQ     <= 1'b0;
      end else begin
         outValidQ <= stgValid & ~Flush;
         // Target/BrEq/BrLT hold across idle cycles; only a live op updates them.
         if (stgValid && !Flush) begin
            takenQ   <= resTaken;
            illegalQ <= isIllegal;
            predQ    <= stgPred;
            targetQ  <= resTarget;
            brEqQ    <= cmpEq;
            brLtQ    <= cmpLt;
         end
      end
   end

   assign OutValid   = outValidQ;
   assign Taken      = outValidQ & takenQ;
   assign IllegalOp  = outValidQ & illegalQ;
   assign Mispredict = outValidQ & (takenQ ^ predQ);
   assign Target     = targetQ;
   assign BrEq       = brEqQ;
   assign BrLT       = brLtQ;

`ifdef BRU_PERF_CNT_EN
   localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0] brCnt;
   logic [CNT_WIDTH-1:0] mispCnt;

   // Counters watch the presented result, so they lag the result by one edge.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         brCnt   <= '0;
         mispCnt <= '0;
      end else if (ClrCnt) begin
         brCnt   <= '0;
         mispCnt <= '0;
      end else begin
         if (OutValid && !IllegalOp && (brCnt != '1)) begin
            brCnt <= brCnt + CntOne;
         end
         if (Mispredict && (mispCnt != '1)) begin
            mispCnt <= mispCnt + CntOne;
         end
      end
   end

   assign BrCount   = brCnt;
   assign MispCount = mispCnt;
`else
   logic unusedClrCnt;
   assign unusedClrCnt = ClrCnt;
   assign BrCount      = '0;
   assign MispCount    = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Directed bench for branch_resolve_unit. Two instances share one input set:
// dut1 is single-stage, dut2 is two-stage; both use 4-bit counters so that
// saturation is reachable. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int CW = 4;
`ifdef BRU_PERF_CNT_EN
   localparam int PerfEn = 1;
`else
   localparam int PerfEn = 0;
`endif

   // Clock / reset
   logic CLK = 1'b0;
   logic RST_n = 1'b0;
   always #5 CLK = ~CLK;

   // Shared stimulus
   logic          InValid = 1'b0;
   logic          Flush = 1'b0;
   logic [2:0]    Funct3 = '0;
   logic [DW-1:0] DataA = '0;
   logic [DW-1:0] DataB = '0;
   logic [AW-1:0] PC = '0;
   logic [AW-1:0] Imm = '0;
   logic          PredTaken = 1'b0;
   logic          ClrCnt = 1'b0;

   // dut1 (PIPE_STAGES=1) outputs
   logic          ov1, tk1, mp1, eq1, lt1, il1;
   logic [AW-1:0] tg1;
   logic [CW-1:0] bc1, mc1;

   // dut2 (PIPE_STAGES=2) outputs
   logic          ov2, tk2, mp2, eq2, lt2, il2;
   logic [AW-1:0] tg2;
   logic [CW-1:0] bc2, mc2;

   int testCount = 0;
   int failCount = 0;

   branch_resolve_unit #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PIPE_STAGES(1), .CNT_WIDTH(CW)
   ) dut1 (
      .CLK(CLK), .RST_n(RST_n), .InValid(InValid), .Flush(Flush),
      .Funct3(Funct3), .DataA(DataA), .DataB(DataB), .PC(PC), .Imm(Imm),
      .PredTaken(PredTaken), .ClrCnt(ClrCnt),
      .OutValid(ov1), .Taken(tk1), .Target(tg1), .Mispredict(mp1),
      .BrEq(eq1), .BrLT(lt1), .IllegalOp(il1),
      .BrCount(bc1), .MispCount(mc1)
   );

   branch_resolve_unit #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PIPE_STAGES(2), .CNT_WIDTH(CW)
   ) dut2 (
      .CLK(CLK), .RST_n(RST_n), .InValid(InValid), .Flush(Flush),
      .Funct3(Funct3), .DataA(DataA), .DataB(DataB), .PC(PC), .Imm(Imm),
      .PredTaken(PredTaken), .ClrCnt(ClrCnt),
      .OutValid(ov2), .Taken(tk2), .Target(tg2), .Mispredict(mp2),
      .BrEq(eq2), .BrLT(lt2), .IllegalOp(il2),
      .BrCount(bc2), .MispCount(mc2)
   );

   // Driver tasks
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic setOp(input logic [2:0] f3, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [AW-1:0] pc,
                        input logic [AW-1:0] imm, input logic pred);
      InValid   = 1'b1;
      Funct3    = f3;
      DataA     = a;
      DataB     = b;
      PC        = pc;
      Imm       = imm;
      PredTaken = pred;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      testCount++;
      assert (obs === exp)
      else begin
         failCount++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // ---- reset state ----
      step();
      step();
      check("rst_ov1", 32'(ov1), 32'h0);
      check("rst_tg1", tg1, 32'h0);
      check("rst_ov2", 32'(ov2), 32'h0);
      check("rst_cnt1", 32'({bc1, mc1}), 32'h0);
      RST_n = 1'b1;
      step();

      // ---- single stage: signed vs unsigned ----
      setOp(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'hFFFF_FFF0, 1'b0); // BLT
      step();
      check("blt_ov", 32'(ov1), 32'h1);
      check("blt_tk", 32'(tk1), 32'h1);
      check("blt_lt", 32'(lt1), 32'h1);
      check("blt_tg", tg1, 32'h0000_00F0);
      check("blt_mp", 32'(mp1), 32'h1);
      check("blt_eq", 32'(eq1), 32'h0);
      setOp(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'hFFFF_FFF0, 1'b0); // BLTU
      step();
      check("bltu_tk", 32'(tk1), 32'h0);
      check("bltu_lt", 32'(lt1), 32'h0);
      check("bltu_mp", 32'(mp1), 32'h0);
      setOp(3'b111, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'hFFFF_FFF0, 1'b0); // BGEU
      step();
      check("bgeu_tk", 32'(tk1), 32'h1);
      check("bgeu_mp", 32'(mp1), 32'h1);
      setOp(3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFF0, 32'h20, 1'b0); // BGE
      step();
      check("bge_tk", 32'(tk1), 32'h0);
      check("bge_lt", 32'(lt1), 32'h1);
      check("bge_wrap_tg", tg1, 32'h10);
      InValid = 1'b0;
      step();
      check("idle_ov1", 32'(ov1), 32'h0);
      check("idle_tk1", 32'(tk1), 32'h0);
      check("idle_tg1_hold", tg1, 32'h10);
      step();
      step();

      // ---- two stages: back-to-back ----
      setOp(3'b000, 32'd5, 32'd5, 32'h200, 32'h8, 1'b1);                 // BEQ
      step();
      check("p2_c1_ov", 32'(ov2), 32'h0);
      setOp(3'b001, 32'd5, 32'd5, 32'h200, 32'h8, 1'b1);                 // BNE
      step();
      check("p2_c2_ov", 32'(ov2), 32'h1);
      check("p2_c2_tk", 32'(tk2), 32'h1);
      check("p2_c2_eq", 32'(eq2), 32'h1);
      check("p2_c2_mp", 32'(mp2), 32'h0);
      setOp(3'b101, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h200, 32'h8, 1'b1); // BGE
      step();
      check("p2_c3_ov", 32'(ov2), 32'h1);
      check("p2_c3_tk", 32'(tk2), 32'h0);
      check("p2_c3_mp", 32'(mp2), 32'h1);
      InValid = 1'b0;
      step();
      check("p2_c4_ov", 32'(ov2), 32'h1);
      check("p2_c4_tk", 32'(tk2), 32'h1);
      check("p2_c4_lt", 32'(lt2), 32'h0);
      check("p2_c4_mp", 32'(mp2), 32'h0);
      step();
      check("p2_c5_ov", 32'(ov2), 32'h0);
      check("p2_c5_tk", 32'(tk2), 32'h0);
      check("p2_c5_tg_hold", tg2, 32'h208);
      check("p2_c5_eq_hold", 32'(eq2), 32'h1);
      step();

      // ---- flush ----
      setOp(3'b000, 32'd5, 32'd5, 32'h300, 32'h4, 1'b0);
      step();
      check("fl_pre_ov1", 32'(ov1), 32'h1);
      Flush = 1'b1;
      setOp(3'b001, 32'd1, 32'd2, 32'h300, 32'h4, 1'b0);
      step();
      check("fl_c1_ov2", 32'(ov2), 32'h0);
      check("fl_c1_ov1", 32'(ov1), 32'h0);
      Flush   = 1'b0;
      InValid = 1'b0;
      step();
      check("fl_c2_ov2", 32'(ov2), 32'h0);
      check("fl_c2_ov1", 32'(ov1), 32'h0);
      step();

      // ---- illegal funct3 ----
      ClrCnt = 1'b1;
      step();
      ClrCnt = 1'b0;
      check("clr_bc1", 32'(bc1), 32'h0);
      check("clr_mc1", 32'(mc1), 32'h0);
      setOp(3'b010, 32'd7, 32'd9, 32'h400, 32'h10, 1'b1);
      step();
      check("ill_ov", 32'(ov1), 32'h1);
      check("ill_il", 32'(il1), 32'h1);
      check("ill_tk", 32'(tk1), 32'h0);
      check("ill_mp", 32'(mp1), 32'h1);
      InValid = 1'b0;
      step();
      check("ill_bc1", 32'(bc1), 32'h0);
      check("ill_mc1", 32'(mc1), 32'(PerfEn));
      check("ill_p2_il", 32'(il2), 32'h1);
      check("ill_p2_mp", 32'(mp2), 32'h1);
      check("ill_p2_tk", 32'(tk2), 32'h0);
      check("idle_il1", 32'(il1), 32'h0);
      step();

      // ---- counter saturation ----
      ClrCnt = 1'b1;
      step();
      ClrCnt = 1'b0;
      for (int i = 0; i < 17; i++) begin
         setOp(3'b000, 32'd1, 32'd2, 32'h500, 32'h4, 1'b1); // not taken, predicted taken
         step();
      end
      InValid = 1'b0;
      step();
      check("sat_bc1", 32'(bc1), 32'(PerfEn ? 15 : 0));
      check("sat_mc1", 32'(mc1), 32'(PerfEn ? 15 : 0));
      step();

      // ---- clear beats a same-cycle increment ----
      setOp(3'b000, 32'd1, 32'd2, 32'h500, 32'h4, 1'b1);
      step();
      check("clr_coinc_ov", 32'(ov1), 32'h1);
      ClrCnt  = 1'b1;
      InValid = 1'b0;
      step();
      ClrCnt = 1'b0;
      check("clr_coinc_bc1", 32'(bc1), 32'h0);
      check("clr_coinc_mc1", 32'(mc1), 32'h0);
      setOp(3'b001, 32'd1, 32'd2, 32'h500, 32'h4, 1'b1); // BNE taken, predicted taken
      step();
      InValid = 1'b0;
      step();
      check("one_bc1", 32'(bc1), 32'(PerfEn));
      check("one_mc1", 32'(mc1), 32'h0);
      step();

      // ---- reset mid-operation ----
      setOp(3'b000, 32'd5, 32'd5, 32'h600, 32'h4, 1'b0);
      step();
      InValid = 1'b0;
      RST_n   = 1'b0;
      #1;
      check("mrst_ov1", 32'(ov1), 32'h0);
      check("mrst_tg1", tg1, 32'h0);
      check("mrst_ov2", 32'(ov2), 32'h0);
      step();
      RST_n = 1'b1;
      step();
      check("mrst_after_ov2", 32'(ov2), 32'h0);
      check("mrst_cnt2", 32'({bc2, mc2}), 32'h0);
      check("mrst_cnt1", 32'({bc1, mc1}), 32'h0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
